seg_readback_monitor: RTL and testbench

//   Receiving end of the timer's six 7-segment buses: samples seg_1..seg_6, waits for a stable

---
 rtl/seg_readback_monitor.sv | 186 ++++++++++++++++++
 tb/tb_seg_readback_monitor.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_readback_monitor.sv
// seg_readback_monitor
//   Samples six active-low 7-segment buses, waits for the pattern to settle
//   for STABLE_CYCLES samples, decodes it back to a 6-digit BCD value and
//   reports new values (bcd_valid) or non-digit patterns (illegal).
//   Optional feature macro: STEP_CHECK_EN -- when defined, every update after
//   the first must advance by exactly one BCD count (or return to 000000);
//   otherwise the sticky step_err flag is raised.
module seg_readback_monitor #(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       seg_1,
  input  logic [6:0]       seg_2,
  input  logic [6:0]       seg_3,
  input  logic [6:0]       seg_4,
  input  logic [6:0]       seg_5,
  input  logic [6:0]       seg_6,
  output logic [23:0]      bcd,
  output logic             bcd_valid,
  output logic             illegal,
  output logic             step_err,
  output logic [CNT_W-1:0] cap_cnt
);

  localparam logic [7:0] STAB_MAX = 8'(STABLE_CYCLES);

  // Index 5 holds seg_1 (most significant digit), index 0 holds seg_6.
  logic [5:0][6:0]  samp_q, samp_d;
  logic [5:0][6:0]  prev_q, prev_d;
  logic [7:0]       stab_q, stab_d;
  logic [23:0]      bcd_q, bcd_d;
  logic             bcd_valid_q, bcd_valid_d;
  logic             illegal_q, illegal_d;
  logic             have_prev_q, have_prev_d;
  logic [CNT_W-1:0] cap_cnt_q, cap_cnt_d;

  logic [5:0][3:0]  dec;
  logic [5:0]       dig_ok;
  logic             capture;
  logic             update;

  // Active-low gfedcba pattern to {legal, digit}; anything else is not a digit.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    logic [4:0] r;
    case (s)
      7'b1000000: r = {1'b1, 4'd0};
      7'b1111001: r = {1'b1, 4'd1};
      7'b0100100: r = {1'b1, 4'd2};
      7'b0110000: r = {1'b1, 4'd3};
      7'b0011001: r = {1'b1, 4'd4};
      7'b0010010: r = {1'b1, 4'd5};
      7'b0000010: r = {1'b1, 4'd6};
      7'b1111000: r = {1'b1, 4'd7};
      7'b0000000: r = {1'b1, 4'd8};
      7'b0010000: r = {1'b1, 4'd9};
      default:    r = {1'b0, 4'd0};
    endcase
    return r;
  endfunction

  // Saturating increment for the capture counter.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  // Input register stage and stability counter.
  always_comb begin
    samp_d = {seg_1, seg_2, seg_3, seg_4, seg_5, seg_6};
    prev_d = samp_q;
    if (samp_q != prev_q) begin
      stab_d = 8'd1;
    end else if (stab_q < STAB_MAX) begin
      stab_d = stab_q + 8'd1;
    end else begin
      stab_d = stab_q;
    end
  end

  // Per-digit decode of the registered sample.
  always_comb begin
    dec    = '0;
    dig_ok = '0;
    for (int i = 0; i < 6; i++) begin
      {dig_ok[i], dec[i]} = seg_decode(samp_q[i]);
    end
  end

  // Capture: fires once per stable episode, when stab first reaches STAB_MAX.
  always_comb begin
    capture     = (stab_d == STAB_MAX) && (stab_q != STAB_MAX);
    update      = 1'b0;
    bcd_d       = bcd_q;
    bcd_valid_d = 1'b0;
    illegal_d   = 1'b0;
    have_prev_d = have_prev_q;
    cap_cnt_d   = cap_cnt_q;
    if (capture) begin
      if (!(&dig_ok)) begin
        illegal_d = 1'b1;
      end else if (!(have_prev_q && (dec == bcd_q))) begin
        update      = 1'b1;
        bcd_d       = dec;
        bcd_valid_d = 1'b1;
        have_prev_d = 1'b1;
        cap_cnt_d   = sat_inc(cap_cnt_q);
      end
    end
  end

`ifdef STEP_CHECK_EN
  logic step_err_q, step_err_d;

  // Six-digit BCD increment with per-digit carry; 999999 wraps to 000000.
  function automatic logic [23:0] bcd_inc(input logic [23:0] v);
    logic [23:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c           = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Sticky sequence check; a return to 000000 is treated as a counter clear.
  always_comb begin
    step_err_d = step_err_q;
    if (update && have_prev_q &&
        !((dec == bcd_inc(bcd_q)) || (dec == 24'h000000))) begin
      step_err_d = 1'b1;
    end
  end

  // Step error flag register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_err_q <= 1'b0;
    end else begin
      step_err_q <= step_err_d;
    end
  end

  assign step_err = step_err_q;
`else
  assign step_err = 1'b0;
`endif

  // State registers; reset discards any pending episode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp_q      <= {6{7'h7F}};
      prev_q      <= {6{7'h7F}};
      stab_q      <= 8'd0;
      bcd_q       <= 24'h000000;
      bcd_valid_q <= 1'b0;
      illegal_q   <= 1'b0;
      have_prev_q <= 1'b0;
      cap_cnt_q   <= '0;
    end else begin
      samp_q      <= samp_d;
      prev_q      <= prev_d;
      stab_q      <= stab_d;
      bcd_q       <= bcd_d;
      bcd_valid_q <= bcd_valid_d;
      illegal_q   <= illegal_d;
      have_prev_q <= have_prev_d;
      cap_cnt_q   <= cap_cnt_d;
    end
  end

  assign bcd       = bcd_q;
  assign bcd_valid = bcd_valid_q;
  assign illegal   = illegal_q;
  assign cap_cnt   = cap_cnt_q;

endmodule

// File: tb/tb_seg_readback_monitor.sv
// Testbench for seg_readback_monitor: directed segment patterns, expected
// events queued at stimulus time and checked by an independent monitor.
module tb_seg_readback_monitor;

`ifdef STEP_CHECK_EN
  localparam logic SE = 1'b1;
`else
  localparam logic SE = 1'b0;
`endif

  typedef struct packed {
    logic        ill;
    logic [23:0] bcd;
    logic [15:0] cnt;
    logic        step;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [6:0]  seg_1, seg_2, seg_3, seg_4, seg_5, seg_6;
  logic [23:0] bcd;
  logic        bcd_valid;
  logic        illegal;
  logic        step_err;
  logic [15:0] cap_cnt;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t mon_e;
  int   lat;

  seg_readback_monitor #(.STABLE_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .seg_1(seg_1), .seg_2(seg_2), .seg_3(seg_3),
    .seg_4(seg_4), .seg_5(seg_5), .seg_6(seg_6),
    .bcd(bcd), .bcd_valid(bcd_valid), .illegal(illegal),
    .step_err(step_err), .cap_cnt(cap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required finish");
    $fatal(1);
  end

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [23:0] v);
    seg_1 = enc(v[23:20]);
    seg_2 = enc(v[19:16]);
    seg_3 = enc(v[15:12]);
    seg_4 = enc(v[11:8]);
    seg_5 = enc(v[7:4]);
    seg_6 = enc(v[3:0]);
  endtask

  task automatic apply(input logic [23:0] v, input bit has_evt, input exp_t e);
    @(posedge clk); #1;
    drive(v);
    if (has_evt) sb.push_back(e);
    repeat (8) @(posedge clk);
  endtask

  task automatic wait_valid(output int l);
    l = 0;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      if (bcd_valid) begin
        l = c;
        break;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_bcd"}, {8'h0, bcd}, 32'h0);
    chk({tag, "_bcd_valid"}, {31'h0, bcd_valid}, 32'h0);
    chk({tag, "_illegal"}, {31'h0, illegal}, 32'h0);
    chk({tag, "_step_err"}, {31'h0, step_err}, 32'h0);
    chk({tag, "_cap_cnt"}, {16'h0, cap_cnt}, 32'h0);
  endtask

  // Monitor: every output event must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && (bcd_valid || illegal)) begin
      chk("valid_illegal_exclusive", {31'h0, bcd_valid & illegal}, 32'h0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: valid=%0b illegal=%0b bcd=%h, required no event",
                 bcd_valid, illegal, bcd);
      end else begin
        mon_e = sb.pop_front();
        chk("evt_kind_illegal", {31'h0, illegal}, {31'h0, mon_e.ill});
        chk("evt_bcd", {8'h0, bcd}, {8'h0, mon_e.bcd});
        chk("evt_cap_cnt", {16'h0, cap_cnt}, {16'h0, mon_e.cnt});
        chk("evt_step_err", {31'h0, step_err}, {31'h0, mon_e.step});
      end
    end
  end

  initial begin
    rst = 1'b0;
    seg_1 = 7'h7F; seg_2 = 7'h7F; seg_3 = 7'h7F;
    seg_4 = 7'h7F; seg_5 = 7'h7F; seg_6 = 7'h7F;
    repeat (3) @(posedge clk); #1;
    check_zero("reset");

    // First capture of all-zero display, latency from change to pulse.
    sb.push_back('{1'b0, 24'h000000, 16'd1, 1'b0});
    rst = 1'b1;
    drive(24'h000000);
    wait_valid(lat);
    chk("first_latency", lat, 32'd5);
    repeat (4) @(posedge clk);

    // Fresh reset, then sequential steps 000009 -> 000010 -> 000011.
    @(posedge clk); #1;
    rst = 1'b0;
    drive(24'h000009);
    sb.push_back('{1'b0, 24'h000009, 16'd1, 1'b0});
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (8) @(posedge clk);
    apply(24'h000010, 1'b1, '{1'b0, 24'h000010, 16'd2, 1'b0});
    apply(24'h000011, 1'b1, '{1'b0, 24'h000011, 16'd3, 1'b0});
    #1;
    chk("step_bcd", {8'h0, bcd}, 32'h000011);
    chk("step_no_err", {31'h0, step_err}, 32'h0);

    // Three-cycle glitch on seg_6, then back to the held value: no event.
    @(posedge clk); #1;
    drive(24'h000015);
    repeat (3) @(posedge clk); #1;
    drive(24'h000011);
    repeat (8) @(posedge clk);

    // Blank digit on seg_3: one illegal pulse, value and count unchanged.
    @(posedge clk); #1;
    drive(24'h000011);
    seg_3 = 7'h7F;
    sb.push_back('{1'b1, 24'h000011, 16'd3, 1'b0});
    repeat (8) @(posedge clk);
    #1;
    chk("illegal_cnt_hold", {16'h0, cap_cnt}, 32'd3);
    apply(24'h000011, 1'b0, '0);

    // Non-sequential jump, then a sequential one: error is sticky.
    apply(24'h000015, 1'b1, '{1'b0, 24'h000015, 16'd4, SE});
    apply(24'h000016, 1'b1, '{1'b0, 24'h000016, 16'd5, SE});
    #1;
    chk("step_err_sticky", {31'h0, step_err}, {31'h0, SE});

    // Reset two samples into an episode; capture must restart from scratch.
    @(posedge clk); #1;
    drive(24'h999999);
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_zero("mid_reset");
    repeat (2) @(posedge clk); #1;
    sb.push_back('{1'b0, 24'h999999, 16'd1, 1'b0});
    rst = 1'b1;
    wait_valid(lat);
    chk("post_reset_latency", lat, 32'd5);
    repeat (4) @(posedge clk);

    // Wrap 999999 -> 000000 and continue: no step error.
    apply(24'h000000, 1'b1, '{1'b0, 24'h000000, 16'd2, 1'b0});
    apply(24'h000001, 1'b1, '{1'b0, 24'h000001, 16'd3, 1'b0});
    #1;
    chk("wrap_no_err", {31'h0, step_err}, 32'h0);

    repeat (4) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
